fifo_pair_packer: RTL

FIFO_PAIR_PACKER -- requirements
Module: fifo_pair_packer

---
 rtl/fifo_pair_packer.sv | 67 ++++++
 1 files changed

// File: rtl/fifo_pair_packer.sv
// fifo_pair_packer: pops two FIFO words and presents them as one packed word with valid/ready handshake.
// Optional out_parity output enabled by defining PACKER_PARITY_EN.
module fifo_pair_packer #(
    parameter int FIFO_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fifo_empty,
    input  logic [FIFO_WIDTH-1:0]   fifo_rd_data,
    output logic                    fifo_rd_en,
    output logic [2*FIFO_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef PACKER_PARITY_EN
    output logic                    out_parity,
`endif
    output logic [7:0]              pair_count
);
    typedef enum logic [2:0] {S_LO, S_LO_RD, S_HI, S_HI_RD, S_OUT} state_t;
    state_t                  r_state, w_next;
    logic [2*FIFO_WIDTH-1:0] r_data, w_data;
    logic [7:0]              r_count;
    assign fifo_rd_en = !reset && (r_state == S_LO || r_state == S_HI) && !fifo_empty;
    assign out_valid  = r_state == S_OUT;
    assign out_data   = r_data;
    assign pair_count = r_count;
    always_comb begin
        w_next = r_state;
        w_data = r_data;
        unique case (r_state)
            S_LO:    w_next = fifo_rd_en ? S_LO_RD : S_LO;
            S_LO_RD: begin
                w_data[FIFO_WIDTH-1:0] = fifo_rd_data;
                w_next = S_HI;
            end
            S_HI:    w_next = fifo_rd_en ? S_HI_RD : S_HI;
            S_HI_RD: begin
                w_data[2*FIFO_WIDTH-1:FIFO_WIDTH] = fifo_rd_data;
                w_next = S_OUT;
            end
            S_OUT:   w_next = out_ready ? S_LO : S_OUT;
            default: w_next = S_LO;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LO;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_data  <= w_data;
            if (r_state == S_OUT && out_ready && r_count != 8'hFF)
                r_count <= r_count + 8'd1;
        end
    end
`ifdef PACKER_PARITY_EN
    logic r_parity;
    always_ff @(posedge clk) begin
        if (reset)
            r_parity <= 1'b0;
        else
            r_parity <= ^w_data;
    end
    assign out_parity = r_parity & out_valid;
`endif
endmodule
